onehot_seq_decoder: RTL and testbench

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with a valid/ready output stage and an optional auto-scan mode. It is the sequential successor of the team's fixed 3-to-8 combinational decoder. It sits between a select source (register file, controller FSM) and a one-hot consumer (bank enables, mux selects, lamp drivers), adding back-pressure and a self-walking sweep of all outputs.

---
 rtl/onehot_seq_decoder.sv | 103 ++++++++++
 tb/tb_onehot_seq_decoder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/onehot_seq_decoder.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with a valid/ready output slot.
// Define ONEHOT_SEQ_DECODER_SCAN_EN to add the self-walking scan sweep.
`timescale 1ns/1ps
module onehot_seq_decoder #(
    parameter int unsigned SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             scan_start,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [(1<<SEL_W)-1:0] out_onehot,
    output logic [SEL_W-1:0] out_sel,
    output logic             busy
);

    localparam int unsigned OUT_W = 1 << SEL_W;

    logic             slot_free;
    logic             load;
    logic [SEL_W-1:0] load_sel;

    assign slot_free = !out_valid || out_ready;

`ifdef ONEHOT_SEQ_DECODER_SCAN_EN
    typedef enum logic {IDLE, SCAN} state_t;

    state_t state_q, state_d;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, load selection and input handshake
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        load_sel = out_sel;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = slot_free && !mode;
                if (!mode && in_valid && slot_free) begin
                    load     = 1'b1;
                    load_sel = in_sel;
                end else if (mode && scan_start && slot_free) begin
                    load     = 1'b1;
                    load_sel = '0;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                // The last index retires without a wrap back to 0
                if (out_valid && out_ready) begin
                    if (out_sel == SEL_W'(OUT_W - 1)) begin
                        state_d = IDLE;
                    end else begin
                        load     = 1'b1;
                        load_sel = out_sel + SEL_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == SCAN);
`else
    logic unused_inputs;

    assign unused_inputs = ^{mode, scan_start};
    assign in_ready      = slot_free;
    assign load          = in_valid && slot_free;
    assign load_sel      = in_sel;
    assign busy          = 1'b0;
`endif

    // Output slot: load, drain to empty, or hold under back-pressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_onehot <= '0;
            out_sel    <= '0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_onehot <= OUT_W'(1) << load_sel;
            out_sel    <= load_sel;
        end else if (slot_free) begin
            out_valid  <= 1'b0;
            out_onehot <= '0;
        end
    end

endmodule

// File: tb/tb_onehot_seq_decoder.sv
// Directed self-checking bench for onehot_seq_decoder (SEL_W = 3, plus 1 and 6 builds).
`timescale 1ns/1ps
module tb_onehot_seq_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode, in_valid, scan_start, out_ready;
    logic [2:0] in_sel;
    logic       in_ready, out_valid, busy;
    logic [7:0] out_onehot;
    logic [2:0] out_sel;

    logic        v_x;
    logic        sel1;
    logic [5:0]  sel6;
    logic        rdy1, val1, busy1, osel1;
    logic [1:0]  oh1;
    logic        rdy6, val6, busy6;
    logic [5:0]  osel6;
    logic [63:0] oh6;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    onehot_seq_decoder #(.SEL_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready), .in_sel(in_sel), .scan_start(scan_start),
        .out_valid(out_valid), .out_ready(out_ready), .out_onehot(out_onehot),
        .out_sel(out_sel), .busy(busy)
    );

    onehot_seq_decoder #(.SEL_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mode(1'b0), .in_valid(v_x),
        .in_ready(rdy1), .in_sel(sel1), .scan_start(1'b0),
        .out_valid(val1), .out_ready(1'b1), .out_onehot(oh1),
        .out_sel(osel1), .busy(busy1)
    );

    onehot_seq_decoder #(.SEL_W(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .mode(1'b0), .in_valid(v_x),
        .in_ready(rdy6), .in_sel(sel6), .scan_start(1'b0),
        .out_valid(val6), .out_ready(1'b1), .out_onehot(oh6),
        .out_sel(osel6), .busy(busy6)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_oh [8];

    initial begin
        exp_oh[0] = 8'h01; exp_oh[1] = 8'h02; exp_oh[2] = 8'h04; exp_oh[3] = 8'h08;
        exp_oh[4] = 8'h10; exp_oh[5] = 8'h20; exp_oh[6] = 8'h40; exp_oh[7] = 8'h80;

        rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_sel = '0;
        scan_start = 1'b0; out_ready = 1'b0;
        v_x = 1'b0; sel1 = 1'b0; sel6 = '0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_onehot", 64'(out_onehot), 64'h00);
        check("rst_out_sel", 64'(out_sel), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Direct decode back-to-back with no bubbles
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_sel   = 3'(i);
            check("dir_in_ready", 64'(in_ready), 64'd1);
            tick();
            check("dir_valid", 64'(out_valid), 64'd1);
            check("dir_onehot", 64'(out_onehot), 64'(exp_oh[i]));
            check("dir_sel", 64'(out_sel), 64'(i));
        end
        in_valid = 1'b0;
        tick();
        check("dir_drain_valid", 64'(out_valid), 64'd0);
        check("dir_drain_onehot", 64'(out_onehot), 64'h00);

        // Back-pressure hold
        in_valid = 1'b1; in_sel = 3'd5;
        tick();
        check("bp_first", 64'(out_onehot), 64'h20);
        out_ready = 1'b0; in_sel = 3'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", 64'(in_ready), 64'd0);
            tick();
            check("bp_hold_onehot", 64'(out_onehot), 64'h20);
            check("bp_hold_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'd1);
        tick();
        check("bp_next_onehot", 64'(out_onehot), 64'h04);
        check("bp_next_sel", 64'(out_sel), 64'd2);
        in_valid = 1'b0;
        tick();
        check("bp_drain_valid", 64'(out_valid), 64'd0);

        // Width boundaries on the 1-bit and 6-bit decoders
        v_x = 1'b1; sel1 = 1'b1; sel6 = 6'd63;
        tick();
        check("w1_onehot", 64'(oh1), 64'h2);
        check("w6_onehot", oh6, 64'h8000_0000_0000_0000);
        check("w6_sel", 64'(osel6), 64'd63);
        sel1 = 1'b0; sel6 = 6'd0;
        tick();
        check("w1_onehot0", 64'(oh1), 64'h1);
        check("w6_onehot0", oh6, 64'h1);
        v_x = 1'b0;
        tick();
        check("w6_drain", 64'(val6), 64'd0);

`ifdef ONEHOT_SEQ_DECODER_SCAN_EN
        // Scan with out_ready held high; in_sel must be refused throughout
        mode = 1'b1; in_valid = 1'b1; in_sel = 3'd6;
        #1;
        check("scan_in_ready", 64'(in_ready), 64'd0);
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        check("scan_busy", 64'(busy), 64'd1);
        check("scan_sel0", 64'(out_sel), 64'd0);
        check("scan_oh0", 64'(out_onehot), 64'h01);
        for (int i = 1; i < 8; i++) begin
            scan_start = (i == 3);
            tick();
            check("scan_sel", 64'(out_sel), 64'(i));
            check("scan_oh", 64'(out_onehot), 64'(exp_oh[i]));
            check("scan_busy_mid", 64'(busy), 64'd1);
        end
        scan_start = 1'b0;
        tick();
        check("scan_end_valid", 64'(out_valid), 64'd0);
        check("scan_end_busy", 64'(busy), 64'd0);
        check("scan_end_onehot", 64'(out_onehot), 64'h00);
        in_valid = 1'b0;

        // Scan with out_ready toggling: each index held two cycles
        out_ready = 1'b0; scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        check("tog_sel0", 64'(out_sel), 64'd0);
        for (int i = 0; i < 8; i++) begin
            out_ready = 1'b0;
            tick();
            check("tog_hold_sel", 64'(out_sel), 64'(i));
            check("tog_hold_valid", 64'(out_valid), 64'd1);
            out_ready = 1'b1;
            tick();
            if (i < 7) begin
                check("tog_next_sel", 64'(out_sel), 64'(i + 1));
            end else begin
                check("tog_end_valid", 64'(out_valid), 64'd0);
                check("tog_end_busy", 64'(busy), 64'd0);
            end
        end

        // Reset at index 4 of a sweep
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        repeat (4) tick();
        check("rs_at4", 64'(out_sel), 64'd4);
        rst_n = 1'b0;
        #1;
        check("rs_valid", 64'(out_valid), 64'd0);
        check("rs_onehot", 64'(out_onehot), 64'h00);
        check("rs_busy", 64'(busy), 64'd0);
`else
        // Without the scan build, mode=1 still decodes and busy stays low
        mode = 1'b1; scan_start = 1'b1; in_valid = 1'b1; in_sel = 3'd6;
        #1;
        check("noscan_in_ready", 64'(in_ready), 64'd1);
        tick();
        check("noscan_onehot", 64'(out_onehot), 64'h40);
        check("noscan_busy", 64'(busy), 64'd0);
        out_ready = 1'b0; in_sel = 3'd4;
        tick();
        check("noscan_hold", 64'(out_onehot), 64'h40);
        scan_start = 1'b0; in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rs_valid", 64'(out_valid), 64'd0);
        check("rs_onehot", 64'(out_onehot), 64'h00);
        check("rs_busy", 64'(busy), 64'd0);
`endif

        @(negedge clk);
        rst_n = 1'b1;
        mode = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_sel = 3'd3;
        tick();
        check("post_rst_onehot", 64'(out_onehot), 64'h08);
        check("post_rst_sel", 64'(out_sel), 64'd3);
        in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
